// File: rtl/hazard_stall_unit_if.sv
// hazard_stall_unit_if: D-stage hazard inputs and stall/forwarding outputs of the hazard unit.
interface hazard_stall_unit_if #(parameter int CNT_W = 32);
    logic [4:0]       d_rs;
    logic [4:0]       d_rt;
    logic [4:0]       d_a3;
    logic [1:0]       d_tuse_rs;
    logic [1:0]       d_tuse_rt;
    logic [1:0]       d_tnew;
    logic             stall;
    logic             flush_e;
    logic [1:0]       fwd_d_rs;
    logic [1:0]       fwd_d_rt;
    logic [1:0]       fwd_e_rs;
    logic [1:0]       fwd_e_rt;
    logic [CNT_W-1:0] stall_count;
    modport master (
        output d_rs, d_rt, d_a3, d_tuse_rs, d_tuse_rt, d_tnew,
        input  stall, flush_e, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, stall_count
    );
    modport slave (
        input  d_rs, d_rt, d_a3, d_tuse_rs, d_tuse_rt, d_tnew,
        output stall, flush_e, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, stall_count
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: Tuse/Tnew stall and forwarding control for the P5 pipeline.
// Tracks destination and remaining Tnew of E/M/W; the youngest matching stage always wins.
module hazard_stall_unit #(parameter int CNT_W = 32) (
    input logic            clk,
    input logic            reset,
    hazard_stall_unit_if.slave hs
);
    logic [4:0]       a3_e, rs_e, rt_e, a3_m, a3_w;
    logic [1:0]       tnew_e, tnew_m;
    logic [CNT_W-1:0] stall_count;
    logic             stall_rs, stall_rt, stall;
    logic [1:0]       fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;

    // An older stage is only consulted when no younger stage holds the same destination.
    function automatic logic hazard(input logic [4:0] x, input logic [1:0] tu,
                                    input logic [4:0] ae, input logic [1:0] te,
                                    input logic [4:0] am, input logic [1:0] tm);
        return x != 5'd0 && tu != 2'd3 && (x == ae ? tu < te : (x == am && tu < tm));
    endfunction

    function automatic logic [1:0] fwd_d(input logic [4:0] x, input logic [1:0] tu,
                                         input logic [4:0] ae, input logic [1:0] te,
                                         input logic [4:0] am, input logic [1:0] tm,
                                         input logic [4:0] aw);
        return (x == 5'd0 || tu == 2'd3) ? 2'd0 :
               x == ae ? (te == 2'd0 ? 2'd3 : 2'd0) :
               x == am ? (tm == 2'd0 ? 2'd2 : 2'd0) :
               x == aw ? 2'd1 : 2'd0;
    endfunction

    function automatic logic [1:0] fwd_e(input logic [4:0] x, input logic [4:0] am,
                                         input logic [1:0] tm, input logic [4:0] aw);
        return x == 5'd0 ? 2'd0 :
               x == am ? (tm == 2'd0 ? 2'd2 : 2'd0) :
               x == aw ? 2'd1 : 2'd0;
    endfunction

    always_comb begin
        stall_rs = hazard(hs.d_rs, hs.d_tuse_rs, a3_e, tnew_e, a3_m, tnew_m);
        stall_rt = hazard(hs.d_rt, hs.d_tuse_rt, a3_e, tnew_e, a3_m, tnew_m);
        stall    = stall_rs | stall_rt;
        fwd_d_rs = fwd_d(hs.d_rs, hs.d_tuse_rs, a3_e, tnew_e, a3_m, tnew_m, a3_w);
        fwd_d_rt = fwd_d(hs.d_rt, hs.d_tuse_rt, a3_e, tnew_e, a3_m, tnew_m, a3_w);
        fwd_e_rs = fwd_e(rs_e, a3_m, tnew_m, a3_w);
        fwd_e_rt = fwd_e(rt_e, a3_m, tnew_m, a3_w);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a3_e        <= '0;
            tnew_e      <= '0;
            rs_e        <= '0;
            rt_e        <= '0;
            a3_m        <= '0;
            tnew_m      <= '0;
            a3_w        <= '0;
            stall_count <= '0;
        end else begin
            a3_e        <= stall ? 5'd0 : hs.d_a3;
            tnew_e      <= stall ? 2'd0 : hs.d_tnew;
            rs_e        <= stall ? 5'd0 : hs.d_rs;
            rt_e        <= stall ? 5'd0 : hs.d_rt;
            a3_m        <= a3_e;
            tnew_m      <= tnew_e == 2'd0 ? 2'd0 : tnew_e - 2'd1;
            a3_w        <= a3_m;
            stall_count <= stall_count + CNT_W'(stall);
        end
    end

    assign hs.stall       = stall;
    assign hs.flush_e     = stall;
    assign hs.fwd_d_rs    = fwd_d_rs;
    assign hs.fwd_d_rt    = fwd_d_rt;
    assign hs.fwd_e_rs    = fwd_e_rs;
    assign hs.fwd_e_rt    = fwd_e_rt;
    assign hs.stall_count = stall_count;
endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: scoreboard bench; expected outputs are queued at drive time, popped at the negedge.
module tb_hazard_stall_unit;
    typedef struct {
        string tag;
        int    stall;
        int    fdrs;
        int    fdrt;
        int    fers;
        int    fert;
        int    cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    hazard_stall_unit_if #(.CNT_W(32)) hs();
    hazard_stall_unit #(.CNT_W(32)) dut (.clk(clk), .reset(reset), .hs(hs));

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic drive(input int rs, input int rt, input int a3, input int tur, input int tut, input int tn);
        hs.d_rs      = 5'(rs);
        hs.d_rt      = 5'(rt);
        hs.d_a3      = 5'(a3);
        hs.d_tuse_rs = 2'(tur);
        hs.d_tuse_rt = 2'(tut);
        hs.d_tnew    = 2'(tn);
    endtask

    task automatic observe();
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 1, 0);
            return;
        end
        e = sb.pop_front();
        check({e.tag, ".stall"}, int'(hs.stall), e.stall);
        check({e.tag, ".flush_e"}, int'(hs.flush_e), e.stall);
        check({e.tag, ".fwd_d_rs"}, int'(hs.fwd_d_rs), e.fdrs);
        check({e.tag, ".fwd_d_rt"}, int'(hs.fwd_d_rt), e.fdrt);
        check({e.tag, ".fwd_e_rs"}, int'(hs.fwd_e_rs), e.fers);
        check({e.tag, ".fwd_e_rt"}, int'(hs.fwd_e_rt), e.fert);
        check({e.tag, ".stall_count"}, int'(hs.stall_count), e.cnt);
    endtask

    task automatic step(input string tag, input int rs, input int rt, input int a3,
                        input int tur, input int tut, input int tn,
                        input int s, input int fdrs, input int fdrt,
                        input int fers, input int fert, input int cnt);
        @(posedge clk);
        #1;
        drive(rs, rt, a3, tur, tut, tn);
        sb.push_back('{tag, s, fdrs, fdrt, fers, fert, cnt});
        @(negedge clk);
        observe();
    endtask

    initial begin
        drive(0, 0, 0, 3, 3, 0);
        #3;
        sb.push_back('{"reset", 0, 0, 0, 0, 0, 0});
        observe();
        #9 reset = 1'b0;
        // lw $8 then beq on $8: two stall cycles, then W forwarding
        step("lw8",      0, 0, 8, 3, 3, 2,   0, 0, 0, 0, 0, 0);
        step("beq_s1",   8, 0, 0, 0, 3, 0,   1, 0, 0, 0, 0, 0);
        step("beq_s2",   8, 0, 0, 0, 3, 0,   1, 0, 0, 0, 0, 1);
        step("beq_go",   8, 0, 0, 0, 3, 0,   0, 1, 0, 0, 0, 2);
        // addu chain: E-stage forwarding from M, then from W
        step("addu9",    0, 0, 9, 3, 3, 1,   0, 0, 0, 0, 0, 2);
        step("addu10",   9, 0, 10, 1, 3, 1,  0, 0, 0, 0, 0, 2);
        step("dep_rt9",  0, 9, 0, 3, 1, 0,   0, 0, 2, 2, 0, 2);
        step("nop_a",    0, 0, 0, 3, 3, 0,   0, 0, 0, 0, 1, 2);
        // jal then jr: forward from E
        step("jal",      0, 0, 31, 3, 3, 0,  0, 0, 0, 0, 0, 2);
        step("jr",       31, 0, 0, 0, 3, 0,  0, 3, 0, 0, 0, 2);
        // writes to $0 are never a hazard; Tuse 3 suppresses stall and forwarding
        step("wr0",      0, 0, 0, 3, 3, 2,   0, 0, 0, 2, 0, 2);
        step("rd0",      0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 2);
        step("wr5",      0, 0, 5, 3, 3, 0,   0, 0, 0, 0, 0, 2);
        step("rt5_tu3",  0, 5, 0, 3, 3, 0,   0, 0, 0, 0, 0, 2);
        // ori $4 shadowed by lw $4: stall on E, stall on M, then W is the lw
        step("ori4",     0, 0, 4, 3, 3, 1,   0, 0, 0, 0, 2, 2);
        step("lw4",      0, 0, 4, 3, 3, 2,   0, 0, 0, 0, 0, 2);
        step("rd4_s1",   4, 0, 0, 0, 3, 0,   1, 0, 0, 0, 0, 2);
        step("rd4_s2",   4, 0, 0, 0, 3, 0,   1, 0, 0, 0, 0, 3);
        step("rd4_go",   4, 0, 0, 0, 3, 0,   0, 1, 0, 0, 0, 4);
        // ready writer in E shadows an unready writer of the same register in M
        step("lw7",      0, 0, 7, 3, 3, 2,   0, 0, 0, 0, 0, 4);
        step("w7",       0, 0, 7, 3, 3, 0,   0, 0, 0, 0, 0, 4);
        step("rd7",      7, 0, 0, 0, 3, 0,   0, 3, 0, 0, 0, 4);
        // reset while stalled
        step("lw8b",     0, 0, 8, 3, 3, 2,   0, 0, 0, 2, 0, 4);
        step("beq8b",    8, 0, 0, 0, 3, 0,   1, 0, 0, 0, 0, 4);
        reset = 1'b1;
        #1;
        sb.push_back('{"mid_reset", 0, 0, 0, 0, 0, 0});
        observe();
        #2 reset = 1'b0;
        step("post_rst", 8, 0, 0, 0, 3, 0,   0, 0, 0, 0, 0, 0);
        step("post_rst2", 0, 0, 0, 3, 3, 0,  0, 0, 0, 0, 0, 0);
        check("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
